// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - pipelined decode stage with register file, write-back bypass and busy scoreboard
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     komut,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [3:0]      aluop,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hata,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  function automatic logic in_range(input logic [4:0] r);
    return int'(r) < NREG;
  endfunction

  // Instruction fields
  logic [6:0] op_f;
  logic [4:0] rd_f;
  logic [2:0] f3_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign op_f  = komut[6:0];
  assign rd_f  = komut[11:7];
  assign f3_f  = komut[14:12];
  assign rs1_f = komut[19:15];
  assign rs2_f = komut[24:20];

  // Architectural state
  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Bundle registers
  logic            out_valid_q, out_valid_d;
  logic [6:0]      opcode_q;
  logic [3:0]      aluop_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic            hata_q;

  // Decode results for the instruction currently offered
  logic            legal_c;
  logic            use_rs1_c;
  logic            use_rs2_c;
  logic            writes_c;
  logic            ok_c;
  logic [3:0]      aluop_raw_c;
  logic [31:0]     imm32_c;
  logic [3:0]      aluop_c;
  logic [4:0]      rd_c;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  logic            hazard_c;
  logic            accept_c;

  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] busy_live;

  // Opcode classification and immediate assembly
  always_comb begin
    legal_c     = 1'b0;
    use_rs1_c   = 1'b0;
    use_rs2_c   = 1'b0;
    writes_c    = 1'b0;
    aluop_raw_c = 4'd0;
    imm32_c     = 32'd0;
    case (op_f)
      OP_R: begin
        legal_c     = 1'b1;
        use_rs1_c   = 1'b1;
        use_rs2_c   = 1'b1;
        writes_c    = 1'b1;
        aluop_raw_c = {komut[30], f3_f};
      end
      OP_I: begin
        legal_c     = 1'b1;
        use_rs1_c   = 1'b1;
        writes_c    = 1'b1;
        aluop_raw_c = {1'b0, f3_f};
        imm32_c     = {{20{komut[31]}}, komut[31:20]};
      end
      OP_U: begin
        legal_c     = 1'b1;
        writes_c    = 1'b1;
        imm32_c     = {komut[31:12], 12'b0};
      end
      OP_B: begin
        legal_c     = 1'b1;
        use_rs1_c   = 1'b1;
        use_rs2_c   = 1'b1;
        aluop_raw_c = {1'b0, f3_f};
        imm32_c     = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Write-back clear vector and the busy view that already accounts for this cycle's wb
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      clr_vec[i] = wb_en && (int'(wb_rd) == i);
    end
    busy_live = busy_q & ~clr_vec;
  end

  // Legality, operand reads with bypass, hazard detection
  always_comb begin
    ok_c = legal_c
        && !(use_rs1_c && !in_range(rs1_f))
        && !(use_rs2_c && !in_range(rs2_f))
        && !(writes_c  && !in_range(rd_f));

    aluop_c   = 4'd0;
    rd_c      = 5'd0;
    imm_c     = '0;
    rs1_val_c = '0;
    rs2_val_c = '0;
    hazard_c  = 1'b0;

    if (ok_c) begin
      aluop_c = aluop_raw_c;
      rd_c    = writes_c ? rd_f : 5'd0;
      imm_c   = XLEN'($signed(imm32_c));
      if (use_rs1_c && rs1_f != 5'd0) begin
        rs1_val_c = (wb_en && wb_rd == rs1_f) ? wb_data : rf_q[rs1_f[AW-1:0]];
      end
      if (use_rs2_c && rs2_f != 5'd0) begin
        rs2_val_c = (wb_en && wb_rd == rs2_f) ? wb_data : rf_q[rs2_f[AW-1:0]];
      end
      hazard_c = (use_rs1_c && busy_live[rs1_f[AW-1:0]])
              || (use_rs2_c && busy_live[rs2_f[AW-1:0]])
              || (writes_c  && busy_live[rd_f[AW-1:0]]);
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !(in_valid && hazard_c);
  assign accept_c = in_valid && in_ready;

  // Next busy state: new destinations set, write-backs clear, set wins on collision
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      set_vec[i] = accept_c && ok_c && writes_c && (rd_f != 5'd0) && (int'(rd_f) == i);
    end
    busy_d      = busy_live | set_vec;
    out_valid_d = accept_c || (out_valid_q && !out_ready);
  end

  // Decode bundle register, loaded on accept and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= 7'd0;
      aluop_q     <= 4'd0;
      rd_q        <= 5'd0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      hata_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept_c) begin
        opcode_q   <= op_f;
        aluop_q    <= aluop_c;
        rd_q       <= rd_c;
        imm_q      <= imm_c;
        rs1_data_q <= rs1_val_c;
        rs2_data_q <= rs2_val_c;
        hata_q     <= !ok_c;
      end
    end
  end

  // Register file write port; x0 and out-of-range indices are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en && wb_rd != 5'd0 && in_range(wb_rd)) begin
      rf_q[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign aluop     = aluop_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign rs1_data  = rs1_data_q;
  assign rs2_data  = rs2_data_q;
  assign hata      = hata_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        hata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: XLEN=32, NREG=32
  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hata, a_wb_en;
  logic [31:0] a_komut, a_imm, a_rs1, a_rs2, a_wb_data;
  logic [6:0]  a_opcode;
  logic [3:0]  a_aluop;
  logic [4:0]  a_rd, a_wb_rd;

  // DUT B: XLEN=64, NREG=16
  logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hata, b_wb_en;
  logic [31:0] b_komut;
  logic [63:0] b_imm, b_rs1, b_rs2, b_wb_data;
  logic [6:0]  b_opcode;
  logic [3:0]  b_aluop;
  logic [4:0]  b_rd, b_wb_rd;

  instr_decode_stage #(.XLEN(32), .NREG(32)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .komut(a_komut),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .opcode(a_opcode), .aluop(a_aluop), .rd(a_rd),
    .imm(a_imm), .rs1_data(a_rs1), .rs2_data(a_rs2), .hata(a_hata),
    .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data)
  );

  instr_decode_stage #(.XLEN(64), .NREG(16)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .komut(b_komut),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .opcode(b_opcode), .aluop(b_aluop), .rd(b_rd),
    .imm(b_imm), .rs1_data(b_rs1), .rs2_data(b_rs2), .hata(b_hata),
    .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_last_pop = 0;
  int a_prev_pop = 0;
  exp_t qa[$];
  exp_t qb[$];

  always @(posedge clk) cyc++;

  function automatic exp_t mk(input logic [6:0] op, input logic [3:0] alu, input logic [4:0] rd,
                              input logic [63:0] imm, input logic [63:0] r1, input logic [63:0] r2,
                              input logic hata);
    exp_t e;
    e.op = op; e.alu = alu; e.rd = rd; e.imm = imm; e.r1 = r1; e.r2 = r2; e.hata = hata;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input string tag, input exp_t e, input logic [6:0] op, input logic [3:0] alu,
                              input logic [4:0] rd, input logic [63:0] imm, input logic [63:0] r1,
                              input logic [63:0] r2, input logic hata);
    cmp({tag, "_opcode"}, {57'd0, op}, {57'd0, e.op});
    cmp({tag, "_aluop"}, {60'd0, alu}, {60'd0, e.alu});
    cmp({tag, "_rd"}, {59'd0, rd}, {59'd0, e.rd});
    cmp({tag, "_imm"}, imm, e.imm);
    cmp({tag, "_rs1_data"}, r1, e.r1);
    cmp({tag, "_rs2_data"}, r2, e.r2);
    cmp({tag, "_hata"}, {63'd0, hata}, {63'd0, e.hata});
  endtask

  // Monitor A: compare on handshake, compare against head while stalled (stability)
  always @(negedge clk) begin
    if (a_rst_n && a_out_valid) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_bundle actual=out_valid=1 required=no bundle (t=%0t)", $time);
      end else if (a_out_ready) begin
        check_bundle("a_out", qa[0], a_opcode, a_aluop, a_rd, {32'd0, a_imm}, {32'd0, a_rs1},
                     {32'd0, a_rs2}, a_hata);
        void'(qa.pop_front());
        a_prev_pop = a_last_pop;
        a_last_pop = cyc;
      end else begin
        check_bundle("a_hold", qa[0], a_opcode, a_aluop, a_rd, {32'd0, a_imm}, {32'd0, a_rs1},
                     {32'd0, a_rs2}, a_hata);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (b_rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_bundle actual=out_valid=1 required=no bundle (t=%0t)", $time);
      end else begin
        check_bundle("b_out", qb[0], b_opcode, b_aluop, b_rd, b_imm, b_rs1, b_rs2, b_hata);
        void'(qb.pop_front());
      end
    end
  end

  // Called at posedge+1; leaves in_valid low at posedge+1 after the accepting edge
  task automatic send_a(input logic [31:0] k, input exp_t e);
    int n = 0;
    a_in_valid = 1'b1;
    a_komut = k;
    #1;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_in_ready) begin
      checks++; failures++;
      $display("FAIL a_accept_timeout actual=in_ready=0 required=accept komut=%h", k);
    end else begin
      qa.push_back(e);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] k, input exp_t e);
    int n = 0;
    b_in_valid = 1'b1;
    b_komut = k;
    #1;
    while (!b_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!b_in_ready) begin
      checks++; failures++;
      $display("FAIL b_accept_timeout actual=in_ready=0 required=accept komut=%h", k);
    end else begin
      qb.push_back(e);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 0; a_in_valid = 0; a_komut = 0; a_out_ready = 1; a_wb_en = 0; a_wb_rd = 0; a_wb_data = 0;
    b_rst_n = 0; b_in_valid = 0; b_komut = 0; b_out_ready = 1; b_wb_en = 0; b_wb_rd = 0; b_wb_data = 0;

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_out_valid", {63'd0, a_out_valid}, 64'd0);
    cmp("reset_opcode", {57'd0, a_opcode}, 64'd0);
    cmp("reset_imm", {32'd0, a_imm}, 64'd0);
    cmp("reset_rs1", {32'd0, a_rs1}, 64'd0);
    cmp("reset_hata", {63'd0, a_hata}, 64'd0);
    cmp("reset_in_ready", {63'd0, a_in_ready}, 64'd1);
    a_rst_n = 1;

    // Preload x11=5, x12=7
    @(posedge clk); #1;
    a_wb_en = 1; a_wb_rd = 5'd11; a_wb_data = 32'd5;
    @(posedge clk); #1;
    a_wb_rd = 5'd12; a_wb_data = 32'd7;
    @(posedge clk); #1;
    a_wb_en = 0;

    // R: sets busy[10]
    send_a(32'h40C58501, mk(7'h01, 4'b1000, 5'd10, 64'd0, 64'd5, 64'd7, 1'b0));

    // Hazard: I reading x10 stalls until wb of x10, then accepts with bypass
    a_in_valid = 1; a_komut = 32'h00350283;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("hazard_stall_in_ready", {63'd0, a_in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    a_wb_en = 1; a_wb_rd = 5'd10; a_wb_data = 32'h55;
    #1;
    cmp("hazard_release_in_ready", {63'd0, a_in_ready}, 64'd1);
    qa.push_back(mk(7'h03, 4'd0, 5'd5, 64'd3, 64'h55, 64'd0, 1'b0));
    @(posedge clk); #1;
    a_in_valid = 0; a_wb_en = 0;

    send_a(32'hE7820F83, mk(7'h03, 4'd0, 5'd31, 64'h00000000FFFFFE78, 64'd0, 64'd0, 1'b0));
    send_a(32'h12345187, mk(7'h07, 4'd0, 5'd3, 64'h0000000012345000, 64'd0, 64'd0, 1'b0));
    send_a(32'hFE000F8F, mk(7'h0F, 4'd0, 5'd0, 64'h00000000FFFFFFFE, 64'd0, 64'd0, 1'b0));
    send_a(32'h12345E7F, mk(7'h7F, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1));
    send_a(32'h00B5000F, mk(7'h0F, 4'd0, 5'd0, 64'd0, 64'h55, 64'd5, 1'b0));

    // Back-pressure
    repeat (2) @(posedge clk);
    #1;
    a_out_ready = 0;
    send_a(32'hFE000F8F, mk(7'h0F, 4'd0, 5'd0, 64'h00000000FFFFFFFE, 64'd0, 64'd0, 1'b0));
    a_in_valid = 1; a_komut = 32'h00C5800F;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp("backpressure_in_ready", {63'd0, a_in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    a_out_ready = 1;
    #1;
    cmp("backpressure_release_in_ready", {63'd0, a_in_ready}, 64'd1);
    qa.push_back(mk(7'h0F, 4'd0, 5'd0, 64'd0, 64'd5, 64'd7, 1'b0));
    @(posedge clk); #1;
    a_in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("backpressure_consecutive", 64'(a_last_pop - a_prev_pop), 64'd1);

    // Reset mid-stall with busy[10] set
    a_out_ready = 0;
    send_a(32'h40C58501, mk(7'h01, 4'b1000, 5'd10, 64'd0, 64'd5, 64'd7, 1'b0));
    @(posedge clk); #2;
    a_rst_n = 0;
    #1;
    cmp("midreset_out_valid", {63'd0, a_out_valid}, 64'd0);
    cmp("midreset_aluop", {60'd0, a_aluop}, 64'd0);
    cmp("midreset_rd", {59'd0, a_rd}, 64'd0);
    cmp("midreset_rs1", {32'd0, a_rs1}, 64'd0);
    cmp("midreset_rs2", {32'd0, a_rs2}, 64'd0);
    cmp("midreset_in_ready", {63'd0, a_in_ready}, 64'd1);
    qa.delete();
    @(posedge clk); #1;
    a_rst_n = 1; a_out_ready = 1;
    a_in_valid = 1; a_komut = 32'h00350283;
    #1;
    cmp("postreset_first_accept", {63'd0, a_in_ready}, 64'd1);
    qa.push_back(mk(7'h03, 4'd0, 5'd5, 64'd3, 64'd0, 64'd0, 1'b0));
    @(posedge clk); #1;
    a_in_valid = 0;
    send_a(32'h40C58501, mk(7'h01, 4'b1000, 5'd10, 64'd0, 64'd0, 64'd0, 1'b0));

    // DUT B: NREG=16, XLEN=64
    b_rst_n = 1;
    @(posedge clk); #1;
    send_b(32'hE7820F83, mk(7'h03, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1));
    send_b(32'h12345187, mk(7'h07, 4'd0, 5'd3, 64'h0000000012345000, 64'd0, 64'd0, 1'b0));
    send_b(32'hE7820283, mk(7'h03, 4'd0, 5'd5, 64'hFFFFFFFFFFFFFE78, 64'd0, 64'd0, 1'b0));

    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    cmp("a_queue_drained", 64'(qa.size()), 64'd0);
    cmp("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
